pipeline_4_writeback: RTL
=========================

Name: pipeline_4_writeback

Overview:
- Final stage of the 16-bit pipelined CPU, directly downstream of the memory/write stage.
- Registers that stage's result, control word, instruction type, flags and load data, then drives the register-file write port.
- Commits the architectural status register (N,V,Z) and owns the HALT state machine that freezes retirement.
- Its write-port outputs also serve as the bypass source for the decode/execute stages.

Parameters:
- PC_W, 9, width of the link-address (PC+1) field
- CNT_W, 16, width of the retired-instruction counter (optional feature only)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- control_in  in  22  control word from memory stage; [2:0] writenum, [3] write, [8] loads (status update)
- inst_type_in  in  6  one-hot: [0] ALU/MOV, [1] STR, [2] LDR, [3] BL (link write), [4] branch, [5] HALT; all-zero = bubble
- result_in  in  16  ALU/address result from memory stage
- N_in, V_in, Z_in  in  1 each  flags produced by memory stage
- pc_in  in  PC_W  PC+1 of the instruction, for link writes
- mdata  in  16  synchronous-RAM read data; valid in the cycle the LDR occupies this stage
- w_en  out  1  register-file write enable
- w_num  out  3  destination register
- w_data  out  16  write data
- status_out  out  3  committed {N,V,Z}
- retire  out  1  an instruction retires this cycle
- halted  out  1  HALT has retired; pipeline frozen

Behaviour:
- Stage register: on each clk edge while in RUN, capture control_in, inst_type_in, result_in, pc_in and {N,V,Z}_in.
- While HALTED, the stage register loads a bubble (all zero).
- Reset (rst=0, asynchronous):
  - All stage registers, status register and state clear to 0.
  - w_en=0, w_num=0, w_data=0, status_out=3'b000, retire=0, halted=0.
  - Reset mid-instruction discards it; the in-flight write does not happen.
- Write data select, combinational from the stage register:
  - LDR: mdata.
  - else BL: zero-extended pc (upper 16-PC_W bits 0).
  - else: result.
  - Priority LDR > BL > ALU when more than one type bit is set (illegal encoding, still deterministic).
- w_en = write bit AND (LDR or BL or ALU) AND state==RUN.
  - STR, branch, HALT and bubble never write, even if the write bit is set.
- w_num = writenum field unchanged. Writes to any of R0-R7 are legal.
- Write latency: the register file captures w_* at the next clk edge, i.e. one cycle after the instruction enters this stage.
- retire = any inst_type bit set AND state==RUN. Bubbles never retire.
- Status register:
  - Updated at the clk edge ending the retiring instruction's cycle, with the staged {N,V,Z}, when the loads bit is set and retire=1.
  - Otherwise it holds.
  - status_out is the register contents (one cycle after retire).
- FSM, states RUN and HALTED:
  - RUN -> HALTED at the clk edge ending the cycle in which a HALT retires. That HALT counts as retired.
  - HALTED -> HALTED until reset.
  - In HALTED: halted=1, w_en=0, retire=0, status frozen, all inputs ignored.
- HALT together with the write or loads bit: the status update still applies (loads honoured), no write occurs.

Optional Feature:
- Macro WB_RETIRE_COUNT_EN.
- Defined:
  - Adds output instret (out, CNT_W).
  - Increments by 1 at each clk edge where retire=1, wrapping from all-ones to 0.
  - Reset to 0; frozen while HALTED.
- Undefined: no port and no counter logic; all other behaviour identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random inputs -> w_en=0, status_out=000, halted=0, retire=0; release, then bubble -> still no write.
- ALU write: inst_type=000001, writenum=5, write=1, result=16'h1234 -> one cycle later w_en=1, w_num=5, w_data=16'h1234, retire=1.
- LDR: inst_type=000100, writenum=2, write=1, result=16'h00A0, mdata=16'hBEEF in stage cycle -> w_data=16'hBEEF.
- BL: pc_in=9'h1F3 -> w_num=7 with w_data=16'h01F3.
- Status: loads=1, N=1, V=0, Z=0 retiring -> status_out=100 next cycle; a following instruction with loads=0 and flags 011 leaves it at 100.
- STR/HALT: STR with write=1 -> w_en=0, retire=1. HALT followed by ALU writes -> halted=1 after HALT, no further w_en or retire, instret (macro on) stops at the HALT count; 2^CNT_W retires wrap instret to 0.

Source files
------------

// File: rtl/pipeline_4_writeback.sv
// rtl/pipeline_4_writeback.sv - writeback stage: register-file write port, status commit, HALT freeze
// Optional retired-instruction counter enabled by WB_RETIRE_COUNT_EN.
module pipeline_4_writeback #(
    parameter int PC_W  = 9,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [21:0]      control_in,
    input  logic [5:0]       inst_type_in,
    input  logic [15:0]      result_in,
    input  logic             N_in,
    input  logic             V_in,
    input  logic             Z_in,
    input  logic [PC_W-1:0]  pc_in,
    input  logic [15:0]      mdata,
    output logic             w_en,
    output logic [2:0]       w_num,
    output logic [15:0]      w_data,
    output logic [2:0]       status_out,
    output logic             retire,
    output logic             halted
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [CNT_W-1:0] instret
`endif
);

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t            state;
    logic [2:0]        writenum_q;
    logic              write_q;
    logic              loads_q;
    logic [5:0]        type_q;
    logic [15:0]       result_q;
    logic [PC_W-1:0]   pc_q;
    logic [2:0]        nvz_q;
    logic [2:0]        status_q;
    logic              run;

    // Only writenum, write and loads are consumed here; the rest of the control word ends upstream.
    wire unused_ctrl = &{1'b0, control_in[21:9], control_in[7:4]};

    assign run = (state == S_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_RUN;
            writenum_q <= 3'd0;
            write_q    <= 1'b0;
            loads_q    <= 1'b0;
            type_q     <= 6'd0;
            result_q   <= 16'd0;
            pc_q       <= '0;
            nvz_q      <= 3'd0;
            status_q   <= 3'd0;
        end else if (state == S_RUN) begin
            writenum_q <= control_in[2:0];
            write_q    <= control_in[3];
            loads_q    <= control_in[8];
            type_q     <= inst_type_in;
            result_q   <= result_in;
            pc_q       <= pc_in;
            nvz_q      <= {N_in, V_in, Z_in};
            if (retire && loads_q)
                status_q <= nvz_q;
            if (type_q[5])
                state <= S_HALTED;
        end else begin
            // Frozen: keep feeding bubbles so nothing stale lingers in the stage.
            writenum_q <= 3'd0;
            write_q    <= 1'b0;
            loads_q    <= 1'b0;
            type_q     <= 6'd0;
            result_q   <= 16'd0;
            pc_q       <= '0;
            nvz_q      <= 3'd0;
        end
    end

    always_comb begin
        w_data = result_q;
        if (type_q[2])
            w_data = mdata;
        else if (type_q[3])
            w_data = {{(16-PC_W){1'b0}}, pc_q};
    end

    assign w_en       = write_q & (type_q[0] | type_q[2] | type_q[3]) & run;
    assign w_num      = writenum_q;
    assign retire     = (|type_q) & run;
    assign halted     = (state == S_HALTED);
    assign status_out = status_q;

`ifdef WB_RETIRE_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            instret <= '0;
        else if (retire)
            instret <= instret + 1'b1;
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule
